// File: rtl/music_seq.sv
// Song sequencer: plays note/beat entries from a 64x8 RAM
// with per-note gap, pause, loop and stop control.
module music_seq #(
  parameter int SYS_CLK  = 50_000_000,
  parameter int TICK_CYC = SYS_CLK / 8,
  parameter int GAP_CYC  = SYS_CLK / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop,
  output logic [4:0] music,
  output logic       busy,
  output logic       done,
  output logic [5:0] addr
);

  localparam int CW = $clog2(7 * TICK_CYC + 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TICK     = CW'(TICK_CYC);
  localparam logic [CW-1:0] GAP_P1   = CW'(GAP_CYC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_NOTE, S_GAP, S_PAUSE, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;
  state_t r_saved, w_saved_nxt;
  state_t w_adv_state;

  logic [7:0]    r_mem [64];
  logic [7:0]    r_rdata;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_adv_cnt;
  logic [CW-1:0] w_note_len;
  logic [5:0]    r_addr, w_addr_nxt, w_adv_addr;
  logic [4:0]    r_note, w_note_nxt, w_adv_note;

  assign w_note_len = CW'(r_rdata[2:0]) * TICK - GAP_P1;

  // Where FETCH/NOTE/GAP would go this cycle; a pause parks here
  always_comb begin
    w_adv_state = r_state;
    w_adv_cnt   = r_cnt;
    w_adv_addr  = r_addr;
    w_adv_note  = r_note;
    unique case (r_state)
      S_FETCH: begin
        if (r_rdata[2:0] == 3'd0) begin
          w_adv_state = S_DONE;
        end else begin
          w_adv_state = S_NOTE;
          w_adv_note  = r_rdata[7:3];
          w_adv_cnt   = w_note_len;
        end
      end
      S_NOTE: begin
        if (r_cnt == '0) begin
          w_adv_state = S_GAP;
          w_adv_cnt   = GAP_LAST;
        end else begin
          w_adv_cnt = r_cnt - ONE;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_adv_cnt = r_cnt - ONE;
        end else if (r_addr == 6'd63) begin
          w_adv_state = S_DONE;
        end else begin
          w_adv_state = S_FETCH;
          w_adv_addr  = r_addr + 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_saved_nxt = r_saved;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_note_nxt  = r_note;
    if (r_state != S_IDLE && stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_addr_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end
        end
        S_FETCH, S_NOTE, S_GAP: begin
          w_cnt_nxt  = w_adv_cnt;
          w_addr_nxt = w_adv_addr;
          w_note_nxt = w_adv_note;
          if (pause) begin
            w_state_nxt = S_PAUSE;
            w_saved_nxt = w_adv_state;
          end else begin
            w_state_nxt = w_adv_state;
          end
        end
        S_PAUSE: begin
          if (!pause) w_state_nxt = r_saved;
        end
        S_DONE: begin
          w_state_nxt = loop ? S_FETCH : S_IDLE;
          w_addr_nxt  = '0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_note  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_note  <= w_note_nxt;
    end
  end

  // Read at the upcoming address so data is ready during FETCH
  always_ff @(posedge clk) begin
    if (rst && wr_en && r_state == S_IDLE)
      r_mem[wr_addr] <= wr_data;
    r_rdata <= r_mem[w_addr_nxt];
  end

  assign music = (r_state == S_NOTE) ? r_note : 5'd0;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign addr  = r_addr;

endmodule
